byte_seg_scan: RTL and testbench
================================

BYTE_SEG_SCAN -- requirements
Module: byte_seg_scan

Interface
REQ-001 SHALL have parameter SHCP_DIV, default 4: clk cycles per shcp period; even, >=4.
REQ-002 SHALL have parameter SCAN_CNT, default 50000: clk cycles per digit dwell; >=16*SHCP_DIV+4.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  reset; synchronous, active-high (1 = reset).
REQ-005 SHALL have port data_in  input  8  unsigned byte to display, read from EEPROM data path.
REQ-006 SHALL have port ds  output  1  serial data to the cascaded 74HC595 chain.
REQ-007 SHALL have port shcp  output  1  595 shift clock.
REQ-008 SHALL have port stcp  output  1  595 storage latch clock.
REQ-009 SHALL have port oe  output  1  595 output enable, active-low.

Function
REQ-010 SHALL display data_in in decimal on the rightmost 3 of 6 common-anode digits: ones at sel bit0, tens at bit1, hundreds at bit2; sel bits 5..3 always 0.
REQ-011 SHALL use active-low segment codes {dp,g,f,e,d,c,b,a}: 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90, blank=FF; dp always off.
REQ-012 SHALL blank leading zeros: hundreds blank if 0; tens blank if hundreds and tens both 0; ones never blank.
REQ-013 SHALL run FSM IDLE -> CONV -> SHIFT -> LATCH -> HOLD; from HOLD go to SHIFT for next digit, or to CONV after digit 2.
REQ-014 IDLE SHALL last exactly 1 cycle after reset release.
REQ-015 CONV SHALL sample data_in on entry and convert to BCD sequentially: double-dabble, 8 cycles, 1 bit per cycle.
REQ-016 data_in changes outside the CONV sample cycle SHALL NOT affect the frame in progress.
REQ-017 SHIFT SHALL send the 14-bit word {seg[7:0], sel[5:0]} LSB first (sel bit0 first, seg bit7 last).
REQ-018 Each bit SHALL take SHCP_DIV cycles: ds updates on phase 0; shcp is low for the first half and high for the second half; 14 shcp rising edges per digit.
REQ-019 LATCH SHALL hold stcp high for exactly 2 cycles, with shcp low and ds held at its last value.
REQ-020 A dwell counter SHALL clear on SHIFT entry; HOLD SHALL exit when the counter reaches SCAN_CNT-1, so each digit period is exactly SCAN_CNT cycles.
REQ-021 Digit order SHALL be ones, tens, hundreds, repeating; the digit index wraps 2->0 via CONV.
REQ-022 oe SHALL stay 1 until the end of the first LATCH, then drop to 0 and stay 0 until reset.
REQ-023 Digit period with CONV SHALL be SCAN_CNT+8 cycles; all other digit periods SHALL be SCAN_CNT cycles.

Reset
REQ-024 While rstn=1 at a clk edge: state IDLE, digit index 0, counters 0, BCD registers 0, ds=0, shcp=0, stcp=0, oe=1.
REQ-025 Reset asserted mid-SHIFT or mid-LATCH SHALL abort with no further shcp or stcp edges; restart from IDLE at digit 0.

Verification
REQ-026 data_in=123 after reset -> first word shifted = sel 000001, seg B0 (bits in order 1,0,0,0,0,0, then 0,0,0,0,1,1,0,1); stcp pulse of 2 cycles; oe falls after it; then tens A4/000010, hundreds F9/000100.
REQ-027 data_in=0 -> ones C0, tens FF, hundreds FF; data_in=5 -> 92, FF, FF; data_in=40 -> C0, 99, FF.
REQ-028 data_in=255 -> ones 92, tens 92, hundreds A4; data_in=100 -> C0, C0, F9 (inner zero not blanked).
REQ-029 data_in 7 -> 200 changed during SHIFT of the ones digit -> tens and hundreds of that frame show FF; next frame after CONV shows C0, C0, A4.
REQ-030 SHCP_DIV=4, SCAN_CNT=100 -> per digit: exactly 14 shcp rises, period 4 cycles, ds stable across each rise, stcp 2 cycles after SHIFT; digit period 100 cycles (108 including CONV).
REQ-031 rstn pulsed for 1 cycle at the 7th bit of SHIFT -> next cycle ds=shcp=stcp=0, oe=1; sequence restarts at ones digit with fresh CONV.

Source files
------------

// File: rtl/byte_seg_scan.sv
// Drives a cascaded 74HC595 chain to show an 8-bit value in decimal on
// the rightmost three digits of a six-digit common-anode display.
`timescale 1ns/1ps
module byte_seg_scan #(
   parameter int unsigned SHCP_DIV = 4,
   parameter int unsigned SCAN_CNT = 50000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [7:0] data_in,
   output logic       ds,
   output logic       shcp,
   output logic       stcp,
   output logic       oe
);

   localparam int unsigned PH_W = $clog2(SHCP_DIV);
   localparam int unsigned DW_W = $clog2(SCAN_CNT);
   localparam logic [PH_W-1:0] PH_LAST  = PH_W'(SHCP_DIV - 1);
   localparam logic [PH_W-1:0] PH_HALF  = PH_W'(SHCP_DIV / 2);
   localparam logic [DW_W-1:0] DW_LAST  = DW_W'(SCAN_CNT - 1);
   localparam logic [3:0]      BIT_LAST = 4'd13;
   localparam logic [3:0]      BLANK    = 4'hF;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CONV  = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_LATCH = 3'd3;
   localparam logic [2:0] S_HOLD  = 3'd4;

   logic [2:0]      state_q, state_d;
   logic [1:0]      digit_q, digit_d;
   logic [3:0]      bit_q, bit_d;
   logic [PH_W-1:0] ph_q, ph_d;
   logic [DW_W-1:0] dwell_q, dwell_d;
   logic [7:0]      bin_q, bin_d;
   logic [11:0]     bcd_q, bcd_d;
   logic            ds_q, ds_d;
   logic            shcp_q, shcp_d;
   logic            stcp_q, stcp_d;
   logic            oe_q, oe_d;

   logic [7:0]  src_bin;
   logic [11:0] src_bcd;
   logic [11:0] adj_bcd;
   logic [7:0]  seg;
   logic [5:0]  sel;
   logic [13:0] word_d;

   function automatic logic [3:0] dab_adj(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   function automatic logic [7:0] seg_code(input logic [3:0] v);
      logic [7:0] s;
      case (v)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h90;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

   // One double-dabble step; the first CONV cycle takes data_in directly
   always_comb begin
      src_bin = (bit_q == 4'd0) ? data_in : bin_q;
      src_bcd = (bit_q == 4'd0) ? 12'd0 : bcd_q;
      adj_bcd = {dab_adj(src_bcd[11:8]), dab_adj(src_bcd[7:4]), dab_adj(src_bcd[3:0])};
   end

   // Next-state logic: sequencing, counters, conversion and oe release
   always_comb begin
      state_d = state_q;
      digit_d = digit_q;
      bit_d   = bit_q;
      ph_d    = ph_q;
      dwell_d = dwell_q + DW_W'(1);
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      oe_d    = oe_q;
      case (state_q)
         S_IDLE: begin
            state_d = S_CONV;
            bit_d   = 4'd0;
         end
         S_CONV: begin
            bcd_d = {adj_bcd[10:0], src_bin[7]};
            bin_d = {src_bin[6:0], 1'b0};
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'd7) begin
               state_d = S_SHIFT;
               bit_d   = 4'd0;
               ph_d    = '0;
               dwell_d = '0;
            end
         end
         S_SHIFT: begin
            if (ph_q == PH_LAST) begin
               ph_d = '0;
               if (bit_q == BIT_LAST) begin
                  state_d = S_LATCH;
                  bit_d   = 4'd0;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end else begin
               ph_d = ph_q + PH_W'(1);
            end
         end
         S_LATCH: begin
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'd1) begin
               state_d = S_HOLD;
               oe_d    = 1'b0;
            end
         end
         S_HOLD: begin
            if (dwell_q == DW_LAST) begin
               bit_d = 4'd0;
               ph_d  = '0;
               if (digit_q == 2'd2) begin
                  digit_d = 2'd0;
                  state_d = S_CONV;
               end else begin
                  digit_d = digit_q + 2'd1;
                  state_d = S_SHIFT;
                  dwell_d = '0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Word for the upcoming digit, with leading-zero blanking
   always_comb begin
      seg = 8'hFF;
      sel = 6'b000000;
      case (digit_d)
         2'd0: begin
            seg = seg_code(bcd_d[3:0]);
            sel = 6'b000001;
         end
         2'd1: begin
            seg = seg_code((bcd_d[11:8] == 4'd0 && bcd_d[7:4] == 4'd0) ? BLANK : bcd_d[7:4]);
            sel = 6'b000010;
         end
         2'd2: begin
            seg = seg_code((bcd_d[11:8] == 4'd0) ? BLANK : bcd_d[11:8]);
            sel = 6'b000100;
         end
         default: begin
            seg = 8'hFF;
            sel = 6'b000000;
         end
      endcase
      word_d = {seg, sel};
   end

   // Pin values follow the next state so they line up with it after the edge
   always_comb begin
      ds_d   = ds_q;
      shcp_d = 1'b0;
      stcp_d = 1'b0;
      if (state_d == S_SHIFT) begin
         ds_d   = word_d[bit_d];
         shcp_d = (ph_d >= PH_HALF);
      end
      if (state_d == S_LATCH) begin
         stcp_d = 1'b1;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rstn) begin
         state_q <= S_IDLE;
         digit_q <= 2'd0;
         bit_q   <= 4'd0;
         ph_q    <= '0;
         dwell_q <= '0;
         bin_q   <= 8'd0;
         bcd_q   <= 12'd0;
         ds_q    <= 1'b0;
         shcp_q  <= 1'b0;
         stcp_q  <= 1'b0;
         oe_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         digit_q <= digit_d;
         bit_q   <= bit_d;
         ph_q    <= ph_d;
         dwell_q <= dwell_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         ds_q    <= ds_d;
         shcp_q  <= shcp_d;
         stcp_q  <= stcp_d;
         oe_q    <= oe_d;
      end
   end

   assign ds   = ds_q;
   assign shcp = shcp_q;
   assign stcp = stcp_q;
   assign oe   = oe_q;

endmodule

// File: tb/tb_byte_seg_scan.sv
// Directed bench for byte_seg_scan: decodes the 595 serial stream per latch.
`timescale 1ns/1ps
module tb_byte_seg_scan;

   logic       clk;
   logic       rstn;
   logic [7:0] data_in;
   logic       ds, shcp, stcp, oe;

   byte_seg_scan #(.SHCP_DIV(4), .SCAN_CNT(100)) dut (
      .clk(clk), .rstn(rstn), .data_in(data_in),
      .ds(ds), .shcp(shcp), .stcp(stcp), .oe(oe)
   );

   typedef struct {
      logic [13:0] w;
      int          nr;
      int          bad;
      int          lat;
      int          slen;
      logic        oe_r;
      logic        oe_f;
   } rec_t;

   rec_t wq[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   rel_cyc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reconstructs each shifted word and its timing, emitted when stcp falls
   logic [13:0] acc = '0;
   int   nrise = 0, bad = 0, slen = 0, last_rise = 0, lat = 0;
   logic p_shcp = 1'b0, p_stcp = 1'b0, p_ds = 1'b0, oe_r = 1'b0;
   always @(negedge clk) begin
      rec_t r;
      if (rstn) begin
         acc = '0; nrise = 0; bad = 0; slen = 0;
         p_shcp = 1'b0; p_stcp = 1'b0; p_ds = 1'b0;
      end else begin
         if (shcp && !p_shcp) begin
            if (nrise != 0 && cyc - last_rise != 4) bad++;
            if (ds !== p_ds) bad++;
            acc = {ds, acc[13:1]};
            nrise++;
            last_rise = cyc;
         end
         if (stcp) begin
            if (!p_stcp) begin
               lat  = cyc;
               oe_r = oe;
            end
            slen++;
            if (shcp) bad++;
         end
         if (!stcp && p_stcp) begin
            r.w = acc; r.nr = nrise; r.bad = bad; r.lat = lat;
            r.slen = slen; r.oe_r = oe_r; r.oe_f = oe;
            wq.push_back(r);
            nrise = 0; bad = 0; slen = 0;
         end
         p_shcp = shcp; p_stcp = stcp; p_ds = ds;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset(input int n);
      @(posedge clk); #1 rstn = 1'b1;
      repeat (n) @(posedge clk);
      #1 rstn = 1'b0;
      wq.delete();
      rel_cyc = cyc;
   endtask

   task automatic get_word(output rec_t r);
      int n = 0;
      while (wq.size() == 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (wq.size() == 0) begin
         check("word_timeout", 32'd1, 32'd0);
         r.w = '0; r.nr = 0; r.bad = 0; r.lat = 0; r.slen = 0; r.oe_r = 1'b0; r.oe_f = 1'b0;
      end else begin
         r = wq.pop_front();
      end
   endtask

   task automatic frame(input logic [7:0] v, input logic [7:0] so, input logic [7:0] st,
                        input logic [7:0] sh);
      rec_t r;
      data_in = v;
      do_reset(2);
      get_word(r); check($sformatf("ones_%0d", v), 32'(r.w), 32'({so, 6'b000001}));
      get_word(r); check($sformatf("tens_%0d", v), 32'(r.w), 32'({st, 6'b000010}));
      get_word(r); check($sformatf("hund_%0d", v), 32'(r.w), 32'({sh, 6'b000100}));
   endtask

   initial begin
      rec_t r0, r1, r2, r3;
      rstn    = 1'b1;
      data_in = 8'd123;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ds", 32'(ds), 32'd0);
      check("rst_shcp", 32'(shcp), 32'd0);
      check("rst_stcp", 32'(stcp), 32'd0);
      check("rst_oe", 32'(oe), 32'd1);
      rstn = 1'b0;
      wq.delete();
      rel_cyc = cyc;

      // 123: first word detail, latch shape, oe release, digit periods
      get_word(r0);
      check("w0_word", 32'(r0.w), 32'({8'hB0, 6'b000001}));
      check("w0_rises", 32'(r0.nr), 32'd14);
      check("w0_timing", 32'(r0.bad), 32'd0);
      check("w0_stcp_len", 32'(r0.slen), 32'd2);
      check("w0_oe_in_latch", 32'(r0.oe_r), 32'd1);
      check("w0_oe_after", 32'(r0.oe_f), 32'd0);
      check("w0_latency", 32'(r0.lat - rel_cyc), 32'd65);
      get_word(r1);
      check("w1_word", 32'(r1.w), 32'({8'hA4, 6'b000010}));
      check("w1_rises", 32'(r1.nr), 32'd14);
      check("w1_timing", 32'(r1.bad), 32'd0);
      check("w1_period", 32'(r1.lat - r0.lat), 32'd100);
      get_word(r2);
      check("w2_word", 32'(r2.w), 32'({8'hF9, 6'b000100}));
      check("w2_period", 32'(r2.lat - r1.lat), 32'd100);
      get_word(r3);
      check("w3_word", 32'(r3.w), 32'({8'hB0, 6'b000001}));
      check("w3_period_conv", 32'(r3.lat - r2.lat), 32'd108);
      check("w3_oe", 32'(r3.oe_r), 32'd0);

      frame(8'd0,   8'hC0, 8'hFF, 8'hFF);
      frame(8'd5,   8'h92, 8'hFF, 8'hFF);
      frame(8'd40,  8'hC0, 8'h99, 8'hFF);
      frame(8'd255, 8'h92, 8'h92, 8'hA4);
      frame(8'd100, 8'hC0, 8'hC0, 8'hF9);

      // data_in changed mid-frame only shows after the next conversion
      data_in = 8'd7;
      do_reset(2);
      repeat (20) @(posedge clk);
      #1 data_in = 8'd200;
      get_word(r0); check("chg_ones_old", 32'(r0.w), 32'({8'hF8, 6'b000001}));
      get_word(r0); check("chg_tens_old", 32'(r0.w), 32'({8'hFF, 6'b000010}));
      get_word(r0); check("chg_hund_old", 32'(r0.w), 32'({8'hFF, 6'b000100}));
      get_word(r0); check("chg_ones_new", 32'(r0.w), 32'({8'hC0, 6'b000001}));
      get_word(r0); check("chg_tens_new", 32'(r0.w), 32'({8'hC0, 6'b000010}));
      get_word(r0); check("chg_hund_new", 32'(r0.w), 32'({8'hA4, 6'b000100}));

      // Reset pulse during the 7th bit of the first shift
      data_in = 8'd1;
      do_reset(2);
      repeat (34) @(posedge clk);
      #1;
      check("mid_ds_bit6", 32'(ds), 32'd1);
      check("mid_shcp_low", 32'(shcp), 32'd0);
      rstn = 1'b1;
      @(posedge clk); #1;
      check("abort_ds", 32'(ds), 32'd0);
      check("abort_shcp", 32'(shcp), 32'd0);
      check("abort_stcp", 32'(stcp), 32'd0);
      check("abort_oe", 32'(oe), 32'd1);
      rstn = 1'b0;
      wq.delete();
      rel_cyc = cyc;
      get_word(r0);
      check("restart_word", 32'(r0.w), 32'({8'hF9, 6'b000001}));
      check("restart_rises", 32'(r0.nr), 32'd14);
      check("restart_latency", 32'(r0.lat - rel_cyc), 32'd65);
      get_word(r1);
      check("restart_tens", 32'(r1.w), 32'({8'hFF, 6'b000010}));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
